// File: rtl/uart_frame_pkg.sv
// Shared constants, FSM encoding and checksum helper for the UART frame packer.
// Sized for the largest supported payload: 8 words of 4 bytes.
package uart_frame_pkg;

    localparam logic [7:0] DEF_START_DEL = 8'hAA;
    localparam logic [7:0] DEF_END_DEL   = 8'h55;
    localparam logic [7:0] DEF_TEST_PID  = 8'h42;
    localparam logic [7:0] DEF_DATA_PID  = 8'h69;

    localparam int unsigned MAX_PAYLOAD_BYTES = 32'd32;
    localparam int unsigned MAX_PAYLOAD_BITS  = 32'd256;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_WAITBUSY = 2'd2,
        ST_WAITFREE = 2'd3
    } frame_state_e;

    // Bytes above the real payload width are zero, so XOR-ing the full vector is harmless.
    function automatic logic [7:0] xor_checksum(input logic [7:0] pid,
                                                input logic [MAX_PAYLOAD_BITS-1:0] payload);
        logic [7:0] acc;
        acc = pid;
        for (int unsigned i = 32'd0; i < MAX_PAYLOAD_BYTES; i++) begin
            acc = acc ^ payload[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/uart_frame_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued frames ({payload, test bit}).
// Push is ignored when full and pop when empty, so callers cannot corrupt the count.
module uart_frame_fifo
    import uart_frame_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd33,
    parameter int unsigned DEPTH = 32'd4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 32'd1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == LVL_W'(DEPTH));
    assign empty     = (count_r == LVL_W'(0));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rd_data   = mem_r[rd_ptr_r];
    assign level     = count_r;

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= LVL_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + LVL_W'(1);
                2'b01:   count_r <= count_r - LVL_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: rtl/uart_tx_frame_packer.sv
// UART transmit framer: queues payload words and emits START, PID, payload,
// optional XOR checksum and END through a tx_start/tx_busy byte handshake.
module uart_tx_frame_packer
    import uart_frame_pkg::*;
#(
    parameter int unsigned NUM_WORDS   = 32'd1,
    parameter int unsigned WORD_BYTES  = 32'd4,
    parameter int unsigned FIFO_DEPTH  = 32'd4,
    parameter int unsigned CHECKSUM_EN = 32'd1,
    parameter int unsigned ACK_TIMEOUT = 32'd16,
    parameter logic [7:0]  START_DEL   = DEF_START_DEL,
    parameter logic [7:0]  END_DEL     = DEF_END_DEL,
    parameter logic [7:0]  TEST_PID    = DEF_TEST_PID,
    parameter logic [7:0]  DATA_PID    = DEF_DATA_PID
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_WORDS*WORD_BYTES*8-1:0]     in_data,
    input  logic                                  in_test,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  tx_busy,
    output logic [7:0]                            tx_data,
    output logic                                  tx_start,
    output logic                                  frame_done,
    output logic                                  ack_timeout,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_level
);

    localparam int unsigned P         = NUM_WORDS * WORD_BYTES;
    localparam int unsigned PB        = P * 32'd8;
    localparam int unsigned FRAME_LEN = P + 32'd3 + CHECKSUM_EN;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
    localparam int unsigned TMO_W     = $clog2(ACK_TIMEOUT);

    localparam logic [CNT_W-1:0] IDX_START    = CNT_W'(0);
    localparam logic [CNT_W-1:0] IDX_PID      = CNT_W'(1);
    localparam logic [CNT_W-1:0] IDX_PAY0     = CNT_W'(2);
    localparam logic [CNT_W-1:0] IDX_PAY_LAST = CNT_W'(P + 32'd1);
    localparam logic [CNT_W-1:0] IDX_CKSUM    = CNT_W'(P + 32'd2);
    localparam logic [CNT_W-1:0] IDX_LAST     = CNT_W'(FRAME_LEN - 32'd1);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(ACK_TIMEOUT - 32'd1);

    frame_state_e          state_r, state_next_s;
    logic [CNT_W-1:0]      byte_cnt_r, byte_cnt_next_s;
    logic [TMO_W-1:0]      tmo_cnt_r, tmo_cnt_next_s;
    logic [7:0]            tx_data_r, tx_data_next_s;
    logic                  tx_start_r, tx_start_next_s;
    logic                  frame_done_r, frame_done_next_s;
    logic                  ack_timeout_r, ack_timeout_next_s;
    logic [PB-1:0]         frame_data_r;
    logic                  frame_test_r;

    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [PB:0]           fifo_rd_data_s;

    logic [7:0]                  pid_s;
    logic [MAX_PAYLOAD_BITS-1:0] payload_ext_s;
    logic [7:0]                  checksum_s;
    logic [CNT_W-1:0]            pay_idx_s;
    logic [7:0]                  payload_byte_s;
    logic [7:0]                  frame_byte_s;

    assign in_ready    = ~fifo_full_s;
    assign push_s      = in_valid & ~fifo_full_s;
    assign tx_data     = tx_data_r;
    assign tx_start    = tx_start_r;
    assign frame_done  = frame_done_r;
    assign ack_timeout = ack_timeout_r;

    uart_frame_fifo #(
        .WIDTH (PB + 32'd1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .wr_data ({in_data, in_test}),
        .pop     (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

    // Byte mux: selects the frame byte addressed by byte_cnt from the frame buffer.
    always_comb begin
        pid_s         = frame_test_r ? TEST_PID : DATA_PID;
        payload_ext_s = {MAX_PAYLOAD_BITS{1'b0}};
        payload_ext_s[PB-1:0] = frame_data_r;
        checksum_s    = xor_checksum(pid_s, payload_ext_s);
        pay_idx_s     = byte_cnt_r - IDX_PAY0;
        payload_byte_s = 8'h00;
        for (int unsigned i = 32'd0; i < P; i++) begin
            payload_byte_s = (pay_idx_s == CNT_W'(i)) ? frame_data_r[i*8 +: 8] : payload_byte_s;
        end
        if (byte_cnt_r == IDX_START) begin
            frame_byte_s = START_DEL;
        end else if (byte_cnt_r == IDX_PID) begin
            frame_byte_s = pid_s;
        end else if (byte_cnt_r <= IDX_PAY_LAST) begin
            frame_byte_s = payload_byte_s;
        end else if ((CHECKSUM_EN != 32'd0) && (byte_cnt_r == IDX_CKSUM)) begin
            frame_byte_s = checksum_s;
        end else begin
            frame_byte_s = END_DEL;
        end
    end

    // FSM next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_next_s       = state_r;
        byte_cnt_next_s    = byte_cnt_r;
        tmo_cnt_next_s     = tmo_cnt_r;
        tx_data_next_s     = tx_data_r;
        tx_start_next_s    = 1'b0;
        frame_done_next_s  = 1'b0;
        ack_timeout_next_s = 1'b0;
        pop_s              = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s           = 1'b1;
                    byte_cnt_next_s = CNT_W'(0);
                    state_next_s    = ST_LOAD;
                end else begin
                    state_next_s    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tx_data_next_s  = frame_byte_s;
                tx_start_next_s = 1'b1;
                tmo_cnt_next_s  = TMO_W'(0);
                state_next_s    = ST_WAITBUSY;
            end
            ST_WAITBUSY: begin
                if (tx_busy) begin
                    state_next_s = ST_WAITFREE;
                end else if ((tmo_cnt_r + TMO_W'(1)) == TMO_LAST) begin
                    tmo_cnt_next_s     = TMO_LAST;
                    ack_timeout_next_s = 1'b1;
                    state_next_s       = ST_IDLE;
                end else begin
                    tmo_cnt_next_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            ST_WAITFREE: begin
                if (tx_busy) begin
                    state_next_s = ST_WAITFREE;
                end else if (byte_cnt_r == IDX_LAST) begin
                    frame_done_next_s = 1'b1;
                    state_next_s      = ST_IDLE;
                end else begin
                    byte_cnt_next_s = byte_cnt_r + CNT_W'(1);
                    state_next_s    = ST_LOAD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, registered outputs and the frame buffer loaded on each pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            byte_cnt_r    <= CNT_W'(0);
            tmo_cnt_r     <= TMO_W'(0);
            tx_data_r     <= 8'h00;
            tx_start_r    <= 1'b0;
            frame_done_r  <= 1'b0;
            ack_timeout_r <= 1'b0;
            frame_data_r  <= {PB{1'b0}};
            frame_test_r  <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            byte_cnt_r    <= byte_cnt_next_s;
            tmo_cnt_r     <= tmo_cnt_next_s;
            tx_data_r     <= tx_data_next_s;
            tx_start_r    <= tx_start_next_s;
            frame_done_r  <= frame_done_next_s;
            ack_timeout_r <= ack_timeout_next_s;
            if (pop_s) begin
                frame_data_r <= fifo_rd_data_s[PB:1];
                frame_test_r <= fifo_rd_data_s[0];
            end else begin
                frame_data_r <= frame_data_r;
                frame_test_r <= frame_test_r;
            end
        end
    end

endmodule
